// File: rtl/cpu_fsm.sv
// Instruction register and Moore controller that sequences the 16-bit datapath.
// Optional build macro CPU_FSM_ILLEGAL_TRAP_EN adds an `illegal` output and a HALT trap state.
module cpu_fsm (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [1:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
    ,
    output logic        illegal
`endif
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_ALU,
        S_WRITE_REG
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu;
    logic is_mvn;
    logic is_cmp;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign is_cmp     = is_alu && (op == 2'b01);

    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};

    // IR only accepts a new word while idle, so a running instruction never sees its fields change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state <= next_state;
            if (load && (state == S_WAIT)) begin
                ir <= in;
            end
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        w          = 1'b0;
        readnum    = 3'd0;
        writenum   = 3'd0;
        write      = 1'b0;
        vsel       = 2'b00;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        shift      = sh;
        ALUop      = op;
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif

        case (state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    next_state = S_WRITE_IMM;
                end else if (is_mov_reg || is_mvn) begin
                    next_state = S_GET_B;
                end else if (is_alu) begin
                    next_state = S_GET_A;
                end else begin
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
                    next_state = S_HALT;
`else
                    next_state = S_WAIT;
`endif
                end
            end
            S_WRITE_IMM: begin
                writenum   = rn;
                vsel       = 2'b01;
                write      = 1'b1;
                next_state = S_WAIT;
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = S_ALU;
            end
            S_ALU: begin
                loadc = 1'b1;
                // MOV reg passes Rm through the adder as 0 + B without touching the flags.
                if (is_mov_reg) begin
                    asel  = 1'b1;
                    ALUop = 2'b00;
                end else begin
                    loads = 1'b1;
                    asel  = is_mvn;
                end
                next_state = is_cmp ? S_WAIT : S_WRITE_REG;
            end
            S_WRITE_REG: begin
                writenum   = rd;
                vsel       = 2'b00;
                write      = 1'b1;
                next_state = S_WAIT;
            end
`ifdef CPU_FSM_ILLEGAL_TRAP_EN
            S_HALT: begin
                illegal = 1'b1;
            end
`endif
            default: begin
                next_state = S_WAIT;
            end
        endcase
    end

endmodule

// File: doc/cpu_fsm.md
Name: cpu_fsm

Overview:
- Instruction register plus Moore controller that sequences the 16-bit datapath (register file, A/B/C pipeline registers, shifter, ALU, status) one instruction at a time.
- Latches an instruction, decodes it and drives every datapath control line: readnum/writenum, loada/loadb/loadc/loads, asel/bsel, vsel, write, shift, ALUop and sign-extended immediates.
- Sits between the instruction source (switches or, later, memory) and the datapath. `w` tells the source when a new instruction may be issued.

Parameters:
- None. Widths are fixed by the 16-bit ISA.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces WAIT and clears IR
- s  in  1  start; sampled only in WAIT
- load  in  1  IR load enable; honoured only when w=1
- in  in  16  instruction word
- w  out  1  1 = idle in WAIT, ready for load/s
- readnum  out  3  register-file read select
- writenum  out  3  register-file write select
- write  out  1  register-file write strobe
- vsel  out  2  writeback mux: 00 = C, 01 = sximm8, 10 = PC, 11 = mdata
- loada, loadb, loadc, loads  out  1 each  datapath register enables
- asel, bsel  out  1 each  1 = A operand forced to 0; 1 = B operand = sximm5
- shift  out  2  shifter op
- ALUop  out  2  ALU op
- sximm8  out  16  sign-extended IR[7:0]
- sximm5  out  16  sign-extended IR[4:0]

Behaviour:
- IR fields: opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], sh = IR[4:3], Rm = IR[2:0].
- IR capture: IR <= in on clk edge when load=1 and w=1. load is ignored while w=0.
- Supported instructions:
  - MOV Rn,#imm8: opcode 110, op 10
  - MOV Rd,Rm{,sh}: opcode 110, op 00
  - ALU Rd,Rn,Rm{,sh}: opcode 101; op is ADD 00, CMP 01, AND 10, MVN 11
  - All other opcode/op combinations are illegal.
- Outputs are purely a function of state and IR (Moore); no input reaches an output combinationally.
- Defaults in every state unless overridden below: all strobes 0, asel=bsel=0, vsel=00, readnum=writenum=0. shift=sh, ALUop=op, sximm8 and sximm5 always driven from IR.
- States and actions:
  - WAIT: w=1. Transition to DECODE when s=1.
  - DECODE: no strobes. Next state is WRITE_IMM for MOV imm, GET_B for MOV reg and MVN, GET_A for ADD/AND/CMP, WAIT for illegal.
  - WRITE_IMM: writenum=Rn, vsel=01, write=1. Next WAIT.
  - GET_A: readnum=Rn, loada=1. Next GET_B.
  - GET_B: readnum=Rm, loadb=1. Next ALU.
  - ALU: loadc=1.
    - MOV reg: asel=1, ALUop forced 00, loads=0.
    - ALU class: loads=1; MVN additionally asel=1.
    - Next WAIT for CMP, otherwise WRITE_REG.
  - WRITE_REG: writenum=Rd, vsel=00, write=1. Next WAIT.
- Busy cycles (w=0) after the s edge: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD/AND 5, illegal 1.
- CMP never asserts write.
- s held high on return to WAIT: one WAIT cycle with w=1, then the same IR re-executes.
- Reset mid-operation: state goes to WAIT and all strobes drop immediately, without waiting for clk. w=1, IR=0. Register-file contents are not the controller's concern.
- Simultaneous load=1 and s=1 in WAIT: IR takes `in` and the state goes to DECODE on the same edge, so the new instruction executes.

Optional Feature:
- Macro: CPU_FSM_ILLEGAL_TRAP_EN
- Defined:
  - Adds output port `illegal` (out, 1).
  - An illegal decode goes to HALT, where w=0, all strobes are 0 and illegal=1.
  - HALT is exited only by reset.
- Undefined:
  - No `illegal` port and no HALT state.
  - An illegal instruction returns silently to WAIT after 1 busy cycle.

Test Plan:
- Reset asserted mid-cycle, then released → w=1, all strobes 0 without a clk edge; IR=0.
- Load 16'hD007 (MOV R0,#7), pulse s → w low 2 cycles; in WRITE_IMM: write=1, writenum=0, vsel=01, sximm8=16'h0007. Repeat with 16'hD1FE → sximm8=16'hFFFE, writenum=1.
- Load 16'hA148 (ADD R2,R1,R0,LSL#1), pulse s → sequence:
  - GET_A: readnum=1, loada=1
  - GET_B: readnum=0, loadb=1
  - ALU: shift=01, ALUop=00, loadc=loads=1
  - WRITE_REG: writenum=2, vsel=00, write=1
  - w low 5 cycles.
  - With the real datapath (R0=7, R1=2) → R2=16.
- Load 16'hA801 (CMP R0,R1) → 4 busy cycles, loads=1 in ALU, write never 1. Load 16'hB861 (MVN R3,R1) → no GET_A, asel=1 in ALU, writenum=3.
- During the ADD sequence, drive load=1 with in=16'hD007 → IR unchanged, ADD completes. Assert reset in GET_B → w=1 immediately, write never pulses.
- Load 16'hE000 (illegal), pulse s →
  - Without the macro: 1 busy cycle, then w=1.
  - With CPU_FSM_ILLEGAL_TRAP_EN: illegal=1 and w=0 indefinitely until reset.
